// File: rtl/registro_ctrl.sv
// Controller for a conditional shift register: loads a word, shifts it out and
// rebuilds it from the serial return path. Optional rotate mode: REGCTRL_ROTATE_EN.
`ifndef LOAD
`define LOAD  2'b10
`endif
`ifndef PUSH
`define PUSH  2'b00
`endif
`ifndef CYCLE
`define CYCLE 2'b01
`endif

// Handshake: START is taken on a rising CLK edge only while READY=1; START
// seen while READY=0 is dropped. DONE is a single-cycle strobe marking RX_DATA.
module registro_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             DIR_IN,
    input  logic             SER_IN,
`ifdef REGCTRL_ROTATE_EN
    input  logic             OP,
`endif
    output logic             READY,
    output logic [1:0]       MODO,
    output logic             ENB,
    output logic             DIR,
    output logic             S_IN,
    output logic [WIDTH-1:0] D,
    input  logic             S_OUT_IN,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             DONE,
    output logic [1:0]       STATE_DBG
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] cap_nx;
    logic             dir_q;
    logic             op_q;
    logic             op_sel;
    logic             cap_en;

`ifdef REGCTRL_ROTATE_EN
    assign op_sel = OP;
`else
    assign op_sel = 1'b0;
`endif

    // The register output is one edge late, so samples trail the PUSH edges by one.
    assign cap_en = !op_q && (((state == ST_SHIFT) && (cnt != '0)) || (state == ST_DRAIN));
    assign cap_nx = dir_q ? {S_OUT_IN, capture[WIDTH-1:1]}
                          : {capture[WIDTH-2:0], S_OUT_IN};
    assign STATE_DBG = state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            word_q  <= '0;
            dir_q   <= 1'b0;
            op_q    <= 1'b0;
            capture <= '0;
            RX_DATA <= '0;
            DONE    <= 1'b0;
        end else begin
            state <= state_nx;
            DONE  <= 1'b0;
            if ((state == ST_IDLE) && START) begin
                word_q <= DATA_IN;
                dir_q  <= DIR_IN;
                op_q   <= op_sel;
            end
            if (state == ST_SHIFT) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (cap_en) begin
                capture <= cap_nx;
            end
            if (state == ST_DRAIN) begin
                DONE <= 1'b1;
                if (!op_q) begin
                    RX_DATA <= cap_nx;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        READY    = 1'b0;
        MODO     = `LOAD;
        ENB      = 1'b0;
        DIR      = 1'b0;
        S_IN     = 1'b0;
        D        = '0;
        case (state)
            ST_IDLE: begin
                READY = 1'b1;
                if (START) begin
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ENB      = 1'b1;
                D        = word_q;
                state_nx = ST_SHIFT;
            end
            ST_SHIFT: begin
                ENB = 1'b1;
                DIR = dir_q;
                if (op_q) begin
                    MODO = `CYCLE;
                end else begin
                    MODO = `PUSH;
                    S_IN = SER_IN;
                end
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_registro_ctrl.sv
// Bench for registro_ctrl: WIDTH=4 and WIDTH=8 instances, each driving a
// behavioural model of the downstream shift register. Rotate test under REGCTRL_ROTATE_EN.
`ifndef LOAD
`define LOAD  2'b10
`endif
`ifndef PUSH
`define PUSH  2'b00
`endif
`ifndef CYCLE
`define CYCLE 2'b01
`endif

module tb_registro_ctrl;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- WIDTH=4 DUT ----------------
  logic       START, DIR_IN, SER_IN, OP;
  logic [3:0] DATA_IN;
  logic       READY, ENB, DIR, S_IN, S_OUT_IN, DONE;
  logic [1:0] MODO, STATE_DBG;
  logic [3:0] D, RX_DATA;

  registro_ctrl #(.WIDTH(4)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .DATA_IN(DATA_IN),
    .DIR_IN(DIR_IN), .SER_IN(SER_IN),
`ifdef REGCTRL_ROTATE_EN
    .OP(OP),
`endif
    .READY(READY), .MODO(MODO), .ENB(ENB), .DIR(DIR), .S_IN(S_IN), .D(D),
    .S_OUT_IN(S_OUT_IN), .RX_DATA(RX_DATA), .DONE(DONE), .STATE_DBG(STATE_DBG)
  );

  // downstream register model, S_OUT registered
  logic [3:0] rq;
  logic       rsout;
  assign S_OUT_IN = rsout;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rq <= '0; rsout <= 1'b0;
    end else if (ENB) begin
      case (MODO)
        `LOAD: rq <= D;
        `PUSH: if (!DIR) begin rsout <= rq[3]; rq <= {rq[2:0], S_IN}; end
               else      begin rsout <= rq[0]; rq <= {S_IN, rq[3:1]}; end
        `CYCLE: if (!DIR) begin rsout <= rq[3]; rq <= {rq[2:0], rq[3]}; end
                else      begin rsout <= rq[0]; rq <= {rq[0], rq[3:1]}; end
        default: ;
      endcase
    end
  end

  // ---------------- WIDTH=8 DUT ----------------
  logic       START8, DIR_IN8, SER_IN8;
  logic [7:0] DATA_IN8;
  logic       READY8, ENB8, DIR8, S_IN8, S_OUT_IN8, DONE8;
  logic [1:0] MODO8, STATE_DBG8;
  logic [7:0] D8, RX_DATA8;
  logic       OP8;

  registro_ctrl #(.WIDTH(8)) u_dut8 (
    .CLK(CLK), .RST_N(RST_N), .START(START8), .DATA_IN(DATA_IN8),
    .DIR_IN(DIR_IN8), .SER_IN(SER_IN8),
`ifdef REGCTRL_ROTATE_EN
    .OP(OP8),
`endif
    .READY(READY8), .MODO(MODO8), .ENB(ENB8), .DIR(DIR8), .S_IN(S_IN8), .D(D8),
    .S_OUT_IN(S_OUT_IN8), .RX_DATA(RX_DATA8), .DONE(DONE8), .STATE_DBG(STATE_DBG8)
  );

  logic [7:0] rq8;
  logic       rsout8;
  assign S_OUT_IN8 = rsout8;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rq8 <= '0; rsout8 <= 1'b0;
    end else if (ENB8) begin
      case (MODO8)
        `LOAD: rq8 <= D8;
        `PUSH: if (!DIR8) begin rsout8 <= rq8[7]; rq8 <= {rq8[6:0], S_IN8}; end
               else       begin rsout8 <= rq8[0]; rq8 <= {S_IN8, rq8[7:1]}; end
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  logic [3:0] exp_reg_q[$];
  int         exp_cyc_q[$];
  logic [7:0] exp8_q[$];
  int         exp8_cyc_q[$];
  logic       prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // monitor for the WIDTH=4 instance
  always @(negedge CLK) begin
    if (DONE) begin
      chk("done_pulse", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        chk("rx_data", {28'd0, RX_DATA}, {28'd0, exp_q.pop_front()});
        chk("reg_q",   {28'd0, rq},      {28'd0, exp_reg_q.pop_front()});
        chk("done_cyc", cyc, exp_cyc_q.pop_front());
      end
    end
    prev_done = DONE;
  end

  // monitor for the WIDTH=8 instance
  always @(negedge CLK) begin
    if (DONE8) begin
      if (exp8_q.size() == 0) begin
        fail_now("unexpected_done8");
      end else begin
        chk("rx_data8", {24'd0, RX_DATA8}, {24'd0, exp8_q.pop_front()});
        chk("done_cyc8", cyc, exp8_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Full transfer on the WIDTH=4 DUT with per-cycle output checks; returns in DRAIN.
  task automatic start_xfer(input logic [3:0] data, input logic dir, input logic ser,
                            input logic op, input logic [3:0] exp_rx, input logic [3:0] exp_reg);
    @(negedge CLK);
    START = 1'b1; DATA_IN = data; DIR_IN = dir; SER_IN = ser; OP = op;
    @(negedge CLK);
    START = 1'b0; DATA_IN = ~data; DIR_IN = ~dir; OP = ~op;
    exp_q.push_back(exp_rx);
    exp_reg_q.push_back(exp_reg);
    exp_cyc_q.push_back(cyc + 6);
    chk("load_enb",  {31'd0, ENB}, 32'd1);
    chk("load_modo", {30'd0, MODO}, {30'd0, `LOAD});
    chk("load_d",    {28'd0, D}, {28'd0, data});
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("shift_modo", {30'd0, MODO}, op ? {30'd0, `CYCLE} : {30'd0, `PUSH});
      chk("shift_dir",  {31'd0, DIR}, {31'd0, dir});
      chk("shift_ready", {31'd0, READY}, 32'd0);
      if (!op) chk("shift_sin", {31'd0, S_IN}, {31'd0, ser});
    end
    @(negedge CLK);
    chk("drain_enb", {31'd0, ENB}, 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || exp8_q.size() != 0) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 60) fail_now("timeout_waiting_done");
  endtask

  task automatic start8(input logic [7:0] data, input logic dir, input logic [7:0] exp_rx);
    @(negedge CLK);
    START8 = 1'b1; DATA_IN8 = data; DIR_IN8 = dir;
    @(negedge CLK);
    START8 = 1'b0; DATA_IN8 = ~data; DIR_IN8 = ~dir;
    exp8_q.push_back(exp_rx);
    exp8_cyc_q.push_back(cyc + 10);
    wait_idle();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", {31'd0, READY}, 32'd1);
    chk("rst_enb",   {31'd0, ENB}, 32'd0);
    chk("rst_modo",  {30'd0, MODO}, {30'd0, `LOAD});
    chk("rst_d",     {28'd0, D}, 32'd0);
    chk("rst_dir",   {31'd0, DIR}, 32'd0);
    chk("rst_sin",   {31'd0, S_IN}, 32'd0);
    chk("rst_done",  {31'd0, DONE}, 32'd0);
    chk("rst_rx",    {28'd0, RX_DATA}, 32'd0);
    chk("rst_state", {30'd0, STATE_DBG}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST_N = 1'b0;
    START = 1'b0; DATA_IN = '0; DIR_IN = 1'b0; SER_IN = 1'b1; OP = 1'b0;
    START8 = 1'b0; DATA_IN8 = '0; DIR_IN8 = 1'b0; SER_IN8 = 1'b0; OP8 = 1'b0;
    #3;
    chk_reset_outputs();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    // basic transfers, back-to-back, DATA_IN/DIR_IN scrambled mid-transfer
    start_xfer(4'b1011, 1'b0, 1'b0, 1'b0, 4'b1011, 4'b0000);
    start_xfer(4'b0110, 1'b1, 1'b1, 1'b0, 4'b0110, 4'b1111);
    start_xfer(4'b1100, 1'b1, 1'b0, 1'b0, 4'b1100, 4'b0000);
    start_xfer(4'b0001, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b1111);
    wait_idle();

    // START held high: one transfer every 7 cycles, DONE cycle accepts again
    @(negedge CLK);
    START = 1'b1; DATA_IN = 4'b0101; DIR_IN = 1'b0; SER_IN = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(4'b0101);
      exp_reg_q.push_back(4'b1111);
      exp_cyc_q.push_back(cyc + 6 + 7 * i);
    end
    repeat (20) @(negedge CLK);
    START = 1'b0;
    wait_idle();

`ifdef REGCTRL_ROTATE_EN
    // rotate: register returns to the loaded word, RX_DATA keeps 0101
    start_xfer(4'b1000, 1'b0, 1'b0, 1'b1, 4'b0101, 4'b1000);
    wait_idle();
`endif

    // reset during SHIFT cycle 2: immediate reset values, no DONE afterwards
    @(negedge CLK);
    START = 1'b1; DATA_IN = 4'b1100; DIR_IN = 1'b0; SER_IN = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 chk_reset_outputs();
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (8) @(negedge CLK);
    start_xfer(4'b1001, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b0000);
    wait_idle();

    // WIDTH=8
    start8(8'hA5, 1'b0, 8'hA5);
    start8(8'h3C, 1'b1, 8'h3C);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
